// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider: FSM states and the
// ready/start levels used between EX and the divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held until EX drops start_i.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    div_state_e           state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [2*WIDTH:0]     work, work_next;
    logic [WIDTH-1:0]     divisor, divisor_next;
    logic                 neg_quot, neg_quot_next;
    logic                 neg_rem, neg_rem_next;
    logic [2*WIDTH-1:0]   result_next;
    logic                 ready_next;

    logic [WIDTH-1:0]     op1_abs, op2_abs;
    logic [WIDTH:0]       partial;
    logic                 fits;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;

    // Operand magnitudes; the most negative value wraps onto itself and is
    // still correct when read as an unsigned magnitude.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // work[2W:W] is the running remainder with the next dividend bit already
    // shifted in; it can be one bit wider than the divisor, hence the compare.
    assign partial  = work[2*WIDTH:WIDTH];
    assign fits     = (partial >= {1'b0, divisor});
    assign diff     = partial[WIDTH-1:0] - divisor;

    assign quot_raw = work[WIDTH-1:0];
    assign rem_raw  = work[2*WIDTH:WIDTH+1];
    assign quot_fix = neg_quot ? -quot_raw : quot_raw;
    assign rem_fix  = neg_rem  ? -rem_raw  : rem_raw;

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        work_next     = work;
        divisor_next  = divisor;
        neg_quot_next = neg_quot;
        neg_rem_next  = neg_rem;
        result_next   = result_o;
        ready_next    = ready_o;

        case (state)
            DivFree: begin
                result_next = '0;
                ready_next  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next    = DivOn;
                        cnt_next      = '0;
                        divisor_next  = op2_abs;
                        work_next     = {{WIDTH{1'b0}}, op1_abs, 1'b0};
                        neg_quot_next = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_next  = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end
            DivByZero: begin
                state_next  = DivEnd;
                result_next = '0;
                ready_next  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end else if (cnt != CNT_W'(WIDTH)) begin
                    work_next = fits ? {diff, work[WIDTH-1:0], 1'b1}
                                     : {work[2*WIDTH-1:0], 1'b0};
                    cnt_next  = cnt + CNT_W'(1);
                end else begin
                    state_next  = DivEnd;
                    result_next = {rem_fix, quot_fix};
                    ready_next  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            work     <= work_next;
            divisor  <= divisor_next;
            neg_quot <= neg_quot_next;
            neg_rem  <= neg_rem_next;
            result_o <= result_next;
            ready_o  <= ready_next;
        end
    end

endmodule
